// File: rtl/clk_div_monitor.sv
// clk_div_monitor
// Measures the half-period of a slow, divider-generated clock (CLK_IN) in cycles
// of the fast system clock CLK. It reports each edge-to-edge interval, declares
// lock after LOCK_CNT consecutive agreeing measurements, and flags loss of the
// monitored clock after TIMEOUT cycles without an edge.
module clk_div_monitor #(
  parameter int CNT_W    = 16,
  parameter int LOCK_CNT = 4,
  parameter int TOL      = 0,
  parameter int TIMEOUT  = 1000
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLK_IN,
  input  logic             EN,
  output logic             EDGE_PULSE,
  output logic [CNT_W-1:0] HALF_PERIOD,
  output logic             MEAS_VALID,
  output logic             LOCKED,
  output logic             TIMEOUT_ERR
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_MEAS = 2'd2;
  localparam logic [1:0] ST_TMO  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]   TOL_C     = (CNT_W+1)'(TOL);
  localparam logic [3:0]       LOCK_C    = 4'(LOCK_CNT);

  logic             sync1_r, sync2_r, sync3_r;
  logic             edge_s;
  logic [1:0]       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [3:0]       match_r, match_nxt_s;
  logic             has_prev_r, has_prev_nxt_s;
  logic             edge_pulse_r;
  logic [CNT_W-1:0] half_period_r, half_period_nxt_s;
  logic             meas_valid_r, meas_valid_nxt_s;
  logic             locked_r, locked_nxt_s;
  logic             timeout_err_r, timeout_err_nxt_s;
  logic [CNT_W:0]   diff_s, abs_diff_s;
  logic             is_match_s;
  logic [3:0]       match_inc_s;

  // edge of the synchronised monitored clock, either direction
  assign edge_s = sync2_r ^ sync3_r;

  // extra bit keeps the signed difference free of wrap-around
  assign diff_s      = {1'b0, cnt_r} - {1'b0, half_period_r};
  assign abs_diff_s  = diff_s[CNT_W] ? ((~diff_s) + {{CNT_W{1'b0}}, 1'b1}) : diff_s;
  assign is_match_s  = has_prev_r && (abs_diff_s <= TOL_C);
  assign match_inc_s = (match_r >= LOCK_C) ? LOCK_C : (match_r + 4'd1);

  // three-flop synchroniser for the asynchronous monitored clock
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
    end else begin
      sync1_r <= CLK_IN;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  // next-state decode for the measurement FSM, counter and lock tracking
  always_comb begin
    state_nxt_s       = state_r;
    cnt_nxt_s         = edge_s ? CNT_ONE : ((cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE));
    half_period_nxt_s = half_period_r;
    meas_valid_nxt_s  = 1'b0;
    match_nxt_s       = match_r;
    has_prev_nxt_s    = has_prev_r;
    locked_nxt_s      = locked_r;
    timeout_err_nxt_s = timeout_err_r;
    if (!EN) begin
      state_nxt_s       = ST_IDLE;
      cnt_nxt_s         = CNT_ZERO;
      match_nxt_s       = 4'd0;
      has_prev_nxt_s    = 1'b0;
      locked_nxt_s      = 1'b0;
      timeout_err_nxt_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s    = ST_ARM;
          cnt_nxt_s      = CNT_ZERO;
          match_nxt_s    = 4'd0;
          has_prev_nxt_s = 1'b0;
        end
        ST_ARM: begin
          // the first edge only starts the interval, nothing is measured yet
          if (edge_s) begin
            state_nxt_s = ST_MEAS;
          end else if (cnt_r == TIMEOUT_C) begin
            state_nxt_s       = ST_TMO;
            timeout_err_nxt_s = 1'b1;
            locked_nxt_s      = 1'b0;
            match_nxt_s       = 4'd0;
            has_prev_nxt_s    = 1'b0;
          end else begin
            state_nxt_s = ST_ARM;
          end
        end
        ST_MEAS: begin
          // an edge coinciding with the timeout count is still a valid edge
          if (edge_s) begin
            half_period_nxt_s = cnt_r;
            meas_valid_nxt_s  = 1'b1;
            has_prev_nxt_s    = 1'b1;
            match_nxt_s       = is_match_s ? match_inc_s : 4'd0;
            locked_nxt_s      = (match_nxt_s == LOCK_C);
          end else if (cnt_r == TIMEOUT_C) begin
            state_nxt_s       = ST_TMO;
            timeout_err_nxt_s = 1'b1;
            locked_nxt_s      = 1'b0;
            match_nxt_s       = 4'd0;
            has_prev_nxt_s    = 1'b0;
          end else begin
            state_nxt_s = ST_MEAS;
          end
        end
        ST_TMO: begin
          match_nxt_s    = 4'd0;
          has_prev_nxt_s = 1'b0;
          locked_nxt_s   = 1'b0;
          if (edge_s) begin
            state_nxt_s       = ST_MEAS;
            timeout_err_nxt_s = 1'b0;
          end else begin
            timeout_err_nxt_s = 1'b1;
          end
        end
        default: begin
          state_nxt_s       = ST_IDLE;
          cnt_nxt_s         = CNT_ZERO;
          match_nxt_s       = 4'd0;
          has_prev_nxt_s    = 1'b0;
          locked_nxt_s      = 1'b0;
          timeout_err_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // state, counter and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r       <= ST_IDLE;
      cnt_r         <= CNT_ZERO;
      match_r       <= 4'd0;
      has_prev_r    <= 1'b0;
      edge_pulse_r  <= 1'b0;
      half_period_r <= CNT_ZERO;
      meas_valid_r  <= 1'b0;
      locked_r      <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      match_r       <= match_nxt_s;
      has_prev_r    <= has_prev_nxt_s;
      edge_pulse_r  <= edge_s & EN;
      half_period_r <= half_period_nxt_s;
      meas_valid_r  <= meas_valid_nxt_s;
      locked_r      <= locked_nxt_s;
      timeout_err_r <= timeout_err_nxt_s;
    end
  end

  assign EDGE_PULSE  = edge_pulse_r;
  assign HALF_PERIOD = half_period_r;
  assign MEAS_VALID  = meas_valid_r;
  assign LOCKED      = locked_r;
  assign TIMEOUT_ERR = timeout_err_r;

endmodule
